// File: rtl/stream_checker_pkg.sv
// Shared types and defaults for the stream checker.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package stream_checker_pkg;

  localparam int DEF_DATA_W = 1;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  // Index bits needed to address a queue of 'depth' entries (the wrap bit is added by the user).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stream_checker_fifo.sv
// In-order queue of expected words: synchronous push/pop, head visible combinationally.
// Latency: a pushed word can be seen at head on the cycle after the push.
// Backpressure: full blocks push even when a pop happens in the same cycle; pop on empty is ignored.
module stream_checker_fifo
  import stream_checker_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int AW    = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_dat,
  output logic [DATA_W-1:0] head_dat,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Wrap bits differ with equal index bits only when the queue holds DEPTH entries.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign head_dat = mem[rd_ptr[AW-1:0]];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Pointer advance; clear drops every stored entry at once.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/stream_checker.sv
// Compares a DUT word stream against queued expected words; counts hits/misses, gives a verdict.
// Latency: counters and underflow update one clock after act_valid; verdict registers on entry to DONE.
// Backpressure: exp_ready = RUN && !full; actual side has none. Option STREAM_CHECKER_FIRST_ERR_EN adds first-mismatch capture.
module stream_checker
  import stream_checker_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              act_valid,
  input  logic [DATA_W-1:0] act_data,
  output logic [CNT_W-1:0]  matched,
  output logic [CNT_W-1:0]  mismatched,
  output logic              underflow,
  output logic              done,
  output logic              pass
`ifdef STREAM_CHECKER_FIRST_ERR_EN
  ,
  output logic              first_err_valid,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_act,
  output logic [CNT_W-1:0]  first_err_idx
`endif
);

  localparam int AW = ptr_w(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  chk_state_t        state;
  logic              in_run;
  logic              push;
  logic              pop;
  logic              hit;
  logic              miss;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] head_dat;
  logic [AW:0]       fifo_count;
  logic [AW:0]       count_after;
  logic [CNT_W-1:0]  matched_nxt;
  logic [CNT_W-1:0]  mismatched_nxt;
  logic              underflow_nxt;
  logic              verdict;

  assign in_run    = (state == RUN);
  assign exp_ready = in_run && !fifo_full;
  assign push      = in_run && exp_valid && !fifo_full;
  // No bypass: a word pushed this cycle cannot serve an act_valid arriving with it.
  assign pop       = in_run && act_valid && !fifo_empty;
  assign hit       = pop && (act_data == head_dat);
  assign miss      = pop && (act_data != head_dat);

  stream_checker_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (start),
    .push     (push),
    .pop      (pop),
    .push_dat (exp_data),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Post-compare values, so a compare landing with finish is part of the verdict.
  always_comb begin
    matched_nxt    = matched;
    mismatched_nxt = mismatched;
    if (hit && (matched != CNT_MAX))     matched_nxt    = matched + CNT_W'(1);
    if (miss && (mismatched != CNT_MAX)) mismatched_nxt = mismatched + CNT_W'(1);
    underflow_nxt  = underflow | (in_run && act_valid && fifo_empty);
    count_after    = fifo_count + (AW+1)'(push) - (AW+1)'(pop);
    verdict        = (mismatched_nxt == '0) && !underflow_nxt &&
                     (count_after == '0) && (matched_nxt != '0);
  end

  // Control FSM with counters; start takes priority over finish and restarts from any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      matched    <= '0;
      mismatched <= '0;
      underflow  <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else if (start) begin
      state      <= RUN;
      matched    <= '0;
      mismatched <= '0;
      underflow  <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else if (state == RUN) begin
      matched    <= matched_nxt;
      mismatched <= mismatched_nxt;
      underflow  <= underflow_nxt;
      if (finish) begin
        state <= DONE;
        done  <= 1'b1;
        pass  <= verdict;
      end
    end
  end

`ifdef STREAM_CHECKER_FIRST_ERR_EN
  logic [CNT_W-1:0] cmp_idx;

  // Compare index (matches included) and one-shot capture of the first mismatch.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      cmp_idx         <= '0;
      first_err_valid <= 1'b0;
      first_err_exp   <= '0;
      first_err_act   <= '0;
      first_err_idx   <= '0;
    end else begin
      if (pop && (cmp_idx != CNT_MAX)) cmp_idx <= cmp_idx + CNT_W'(1);
      if (miss && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_exp   <= head_dat;
        first_err_act   <= act_data;
        first_err_idx   <= cmp_idx;
      end
    end
  end
`endif

endmodule
